// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier that borrows the shared 64-bit ALU.
// N add cycles build the 2N-bit product in {hi,lo}; one pass-through cycle tests hi for overflow.
module alu_mul_seq #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] product,
   output logic         overflow,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   input  logic [N-1:0] alu_result,
   input  logic         alu_zero,
   output logic [1:0]   dbg_state
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_PASS = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_CHK  = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_m;
   logic [N-1:0]    r_hi;
   logic [N-1:0]    r_lo;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_product;
   logic            r_overflow;
   logic            r_done;
   logic            w_carry;

   // The ALU sum wrapped iff it ended up below the accumulator it was added to.
   assign w_carry = (alu_result < r_hi);

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = ALU_PASS;
      case (r_state)
         S_RUN: begin
            alu_a    = r_hi;
            alu_b    = r_lo[0] ? r_m : '0;
            alu_ctrl = ALU_ADD;
         end
         S_CHK: begin
            alu_b    = r_hi;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_m        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_cnt      <= '0;
         r_product  <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m     <= op_a;
                  r_hi    <= '0;
                  r_lo    <= op_b;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_hi  <= {w_carry, alu_result[N-1:1]};
               r_lo  <= {alu_result[0], r_lo[N-1:1]};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(N - 1)) begin
                  r_state <= S_CHK;
               end
            end
            S_CHK: begin
               r_product  <= r_lo;
               r_overflow <= ~alu_zero;
               r_done     <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign product   = r_product;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU beside the DUT, 2N-bit arithmetic reference,
// directed and random multiplies checked cycle by cycle.
module tb_alu_mul_seq;

   localparam int N = 64;

   logic         clk;
   logic         reset;
   logic         start;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         busy;
   logic         done;
   logic [N-1:0] product;
   logic         overflow;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_ctrl;
   logic [N-1:0] alu_result;
   logic         alu_zero;
   logic [1:0]   dbg_state;

   int n_checks;
   int n_errors;
   logic [N:0]   exp_q[$];
   logic [N-1:0] last_prod;
   logic         last_ovf;

   alu_mul_seq #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .overflow   (overflow),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .dbg_state  (dbg_state)
   );

   // Shared ALU: only add and pass-b matter here.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0010: alu_result = alu_a + alu_b;
         4'b0111: alu_result = alu_b;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*N-1:0] full_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] wa;
      logic [2*N-1:0] wb;
      wa = {{N{1'b0}}, a};
      wb = {{N{1'b0}}, b};
      return wa * wb;
   endfunction

   // Accumulator after k shift-add steps: a*(b mod 2^k) scaled down by 2^k.
   function automatic logic [N-1:0] partial_hi(input logic [N-1:0] a, input logic [N-1:0] b, input int k);
      logic [2*N-1:0] mask;
      logic [2*N-1:0] p;
      mask = ({{(2*N-1){1'b0}}, 1'b1} << k) - 1;
      p    = full_mul(a, {N{1'b0}} | N'(({{N{1'b0}}, b}) & mask));
      return N'(p >> k);
   endfunction

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold, input bit inject);
      logic [2*N-1:0] full;
      logic [N:0]     exp;
      full = full_mul(a, b);
      chk("idle_busy", N'(busy), N'(0));
      chk("idle_ctrl", N'(alu_ctrl), N'(4'b0111));
      chk("idle_alu_a", alu_a, '0);
      chk("idle_alu_b", alu_b, '0);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      exp_q.push_back({|full[2*N-1:N], full[N-1:0]});
      tick();
      if (!hold) start = 1'b0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      for (int k = 0; k < N; k++) begin
         chk($sformatf("run_busy_%0d", k), N'(busy), N'(1));
         chk($sformatf("run_done_%0d", k), N'(done), N'(0));
         chk($sformatf("run_ctrl_%0d", k), N'(alu_ctrl), N'(4'b0010));
         chk($sformatf("run_alu_a_%0d", k), alu_a, partial_hi(a, b, k));
         chk($sformatf("run_alu_b_%0d", k), alu_b, b[k] ? a : '0);
         chk($sformatf("run_prod_held_%0d", k), product, last_prod);
         chk($sformatf("run_ovf_held_%0d", k), N'(overflow), N'(last_ovf));
         if (inject && k == 5) begin
            start = 1'b1;
            op_a  = 7;
            op_b  = 9;
         end
         if (inject && k == 6) start = 1'b0;
         tick();
      end
      chk("chk_busy", N'(busy), N'(1));
      chk("chk_done", N'(done), N'(0));
      chk("chk_ctrl", N'(alu_ctrl), N'(4'b0111));
      chk("chk_alu_a", alu_a, '0);
      chk("chk_alu_b", alu_b, full[2*N-1:N]);
      tick();
      chk("done_pulse", N'(done), N'(1));
      chk("done_busy", N'(busy), N'(0));
      chk("done_q_nonempty", N'(exp_q.size()), N'(1));
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         chk("product", product, exp[N-1:0]);
         chk("overflow", N'(overflow), N'(exp[N]));
      end
      last_prod = full[N-1:0];
      last_ovf  = |full[2*N-1:N];
      if (!hold) begin
         start = 1'b0;
         tick();
         chk("done_single", N'(done), N'(0));
         chk("after_busy", N'(busy), N'(0));
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      last_prod = '0;
      last_ovf  = 1'b0;
      reset = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #12;
      chk("rst_busy", N'(busy), N'(0));
      chk("rst_done", N'(done), N'(0));
      chk("rst_product", product, '0);
      chk("rst_overflow", N'(overflow), N'(0));
      chk("rst_alu_a", alu_a, '0);
      chk("rst_alu_b", alu_b, '0);
      chk("rst_ctrl", N'(alu_ctrl), N'(4'b0111));
      #5 reset = 1'b0;
      tick();

      run_op(3, 5, 1'b0, 1'b0);
      run_op({N{1'b1}}, {N{1'b1}}, 1'b0, 1'b0);
      run_op(64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0);
      run_op(64'h8000_0000_0000_0000, 1, 1'b0, 1'b0);
      run_op(0, 64'hDEAD_BEEF, 1'b0, 1'b1);
      run_op(6, 7, 1'b1, 1'b0);
      run_op(10, 10, 1'b0, 1'b0);

      // Abort 3*5 mid-run with an asynchronous reset.
      op_a  = 3;
      op_b  = 5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      #3 reset = 1'b1;
      #1;
      chk("abort_busy", N'(busy), N'(0));
      chk("abort_done", N'(done), N'(0));
      chk("abort_product", product, '0);
      chk("abort_overflow", N'(overflow), N'(0));
      chk("abort_ctrl", N'(alu_ctrl), N'(4'b0111));
      chk("abort_alu_b", alu_b, '0);
      #10 reset = 1'b0;
      last_prod = '0;
      last_ovf  = 1'b0;
      tick();
      for (int k = 0; k < N + 3; k++) begin
         chk($sformatf("abort_no_done_%0d", k), N'(done), N'(0));
         tick();
      end
      run_op(4, 4, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         logic [N-1:0] ra;
         logic [N-1:0] rb;
         ra = {$urandom, $urandom};
         rb = (r % 2 == 0) ? N'($urandom) : {$urandom, $urandom};
         run_op(ra, rb, 1'b0, (r == 3));
      end

      chk("queue_drained", N'(exp_q.size()), N'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
